// File: rtl/sa_pkg.sv
// sa_pkg: shared types and constants for the 4x4 systolic matmul sequencer.
//   - sa_state_e  : sequencer FSM state encoding
//   - geometry    : array size, instruction/K width, bank column and output address widths
//   - skew        : per-job column padding (first job is one column shorter)
//   - job_len()   : number of bank columns a job streams
package sa_pkg;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int K_W       = 5;
  localparam int COL_W     = 8;
  localparam int OUT_AW    = 7;
  localparam int INSTR_AW  = 3;
  localparam int DRAIN_CYC = 2;
  localparam int SEL_W     = $clog2(ROWS * COLS);

  // Column lengths/bases carry one extra bit so col_base+len never wraps.
  localparam logic [COL_W:0] SKEW_FIRST = (COL_W + 1)'(6);
  localparam logic [COL_W:0] SKEW_NEXT  = (COL_W + 1)'(7);
  localparam logic [COL_W:0] COL_SPAN   = {1'b1, {COL_W{1'b0}}};

  localparam logic [INSTR_AW-1:0] LAST_SLOT  = '1;
  localparam logic [SEL_W-1:0]    SEL_LAST   = '1;
  localparam logic [1:0]          DRAIN_LOAD = 2'(DRAIN_CYC);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    CLEAR,
    STREAM,
    DRAIN,
    WRITE,
    DONE
  } sa_state_e;

  function automatic logic [COL_W:0] job_len(input logic [K_W-1:0] k, input logic first);
    return {{(COL_W + 1 - K_W){1'b0}}, k} + (first ? SKEW_FIRST : SKEW_NEXT);
  endfunction

endpackage

// File: rtl/sa_col_gen.sv
// sa_col_gen: loadable column counter driving the A/B bank read port.
//   clk, rst   : clock, synchronous active-low reset
//   start      : load base/len; reads begin on the following cycle
//   base       : first column of the burst
//   len        : number of columns in the burst (>= 1)
//   mem_col    : column address presented to every bank (0 when not reading)
//   mem_rd_en  : read strobe, high for exactly len cycles after start
//   last       : high on the final read cycle of the burst
module sa_col_gen
  import sa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [COL_W-1:0] base,
  input  logic [COL_W:0]   len,
  output logic [COL_W-1:0] mem_col,
  output logic             mem_rd_en,
  output logic             last
);

  // Reads still owed after the current one; burst ends at terminal count 0.
  logic [COL_W:0] remain;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_col   <= '0;
      mem_rd_en <= 1'b0;
      remain    <= '0;
    end else if (start) begin
      mem_col   <= base;
      mem_rd_en <= (len != '0);
      remain    <= len - 1'b1;
    end else if (mem_rd_en) begin
      if (remain == '0) begin
        mem_rd_en <= 1'b0;
        mem_col   <= '0;
      end else begin
        mem_col <= mem_col + 1'b1;
        remain  <= remain - 1'b1;
      end
    end
  end

  assign last = mem_rd_en && (remain == '0);

endmodule

// File: rtl/sa_sequencer.sv
// sa_sequencer: central controller for the 4x4 systolic matmul core.
// Walks instruction memory on ap_start; every nonzero entry is one job of inner
// dimension K. Each job clears the array, streams pre-skewed bank columns,
// waits for the array to drain and writes the 16 accumulators to 16*job.
//   clk, rst    : clock, synchronous active-low reset (aborts silently)
//   ap_start    : start pulse, only honoured in IDLE
//   ap_done     : 1-cycle pulse when the list ends (terminator or overflow)
//   busy        : high outside IDLE
//   err         : sticky column-overflow flag, cleared by an accepted start
//   instr_addr  : instruction read address (data returns one cycle later)
//   instr_data  : instruction read data (K)
//   curr_instr  : K of the job in progress, 0 when finished
//   mem_rd_en   : bank read strobe, mem_col : bank column address
//   arr_clr     : accumulator clear pulse, arr_en : array MAC/shift enable
//   out_sel     : PE result select, out_addr : output address, out_we : write enable
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for ap_start
// FETCH  | instr_addr = job, read issued
// DECODE | K available; pick terminate / overflow / run
// CLEAR  | arr_clr pulse, column generator loaded
// STREAM | len bank reads, one column per cycle
// DRAIN  | bank + array pipeline latency (1 + DRAIN_CYC cycles)
// WRITE  | 16 result writes, then advance job and col_base
// DONE   | ap_done pulse, back to IDLE
module sa_sequencer
  import sa_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                busy,
  output logic                err,
  output logic [INSTR_AW-1:0] instr_addr,
  input  logic [K_W-1:0]      instr_data,
  output logic [K_W-1:0]      curr_instr,
  output logic                mem_rd_en,
  output logic [COL_W-1:0]    mem_col,
  output logic                arr_clr,
  output logic                arr_en,
  output logic [SEL_W-1:0]    out_sel,
  output logic [OUT_AW-1:0]   out_addr,
  output logic                out_we
);

  sa_state_e           state;
  logic [INSTR_AW-1:0] job;
  logic [COL_W:0]      col_base;
  logic [COL_W:0]      len_q;
  logic [1:0]          drain_cnt;

  logic [COL_W:0]      len_dec;
  logic [COL_W:0]      end_dec;
  logic                cg_start;
  logic                cg_last;

  assign len_dec  = job_len(instr_data, job == '0);
  assign end_dec  = col_base + len_dec;
  // Loading at the end of CLEAR puts the first read in the first STREAM cycle.
  assign cg_start = (state == CLEAR);

  sa_col_gen u_col_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (cg_start),
    .base      (col_base[COL_W-1:0]),
    .len       (len_q),
    .mem_col   (mem_col),
    .mem_rd_en (mem_rd_en),
    .last      (cg_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      job        <= '0;
      col_base   <= '0;
      len_q      <= '0;
      drain_cnt  <= '0;
      ap_done    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      instr_addr <= '0;
      curr_instr <= '0;
      arr_clr    <= 1'b0;
      arr_en     <= 1'b0;
      out_sel    <= '0;
      out_addr   <= '0;
      out_we     <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      arr_clr <= 1'b0;
      // Banks return data one cycle after the strobe.
      arr_en  <= mem_rd_en;

      case (state)
        IDLE: begin
          if (ap_start) begin
            job        <= '0;
            col_base   <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            instr_addr <= '0;
            state      <= FETCH;
          end
        end

        FETCH: begin
          instr_addr <= '0;
          state      <= DECODE;
        end

        DECODE: begin
          if (instr_data == '0 || job == LAST_SLOT) begin
            ap_done    <= 1'b1;
            curr_instr <= '0;
            state      <= DONE;
          end else if (end_dec > COL_SPAN) begin
            err        <= 1'b1;
            ap_done    <= 1'b1;
            curr_instr <= '0;
            state      <= DONE;
          end else begin
            len_q      <= len_dec;
            curr_instr <= instr_data;
            arr_clr    <= 1'b1;
            state      <= CLEAR;
          end
        end

        CLEAR: begin
          state <= STREAM;
        end

        STREAM: begin
          if (cg_last) begin
            drain_cnt <= DRAIN_LOAD;
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          if (drain_cnt == '0) begin
            out_we   <= 1'b1;
            out_sel  <= '0;
            out_addr <= {job, {SEL_W{1'b0}}};
            state    <= WRITE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end

        WRITE: begin
          if (out_sel == SEL_LAST) begin
            out_we     <= 1'b0;
            out_sel    <= '0;
            out_addr   <= '0;
            col_base   <= col_base + len_q;
            job        <= job + 1'b1;
            instr_addr <= job + 1'b1;
            state      <= FETCH;
          end else begin
            out_sel  <= out_sel + 1'b1;
            out_addr <= out_addr + 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
